// File: rtl/udp_rx_parser.sv
// GMII receive parser: filters Ethernet/IPv4/UDP headers, streams UDP payload, checks FCS per frame.
// Payload byte appears one cycle after it arrives; no backpressure, the consumer takes every valid cycle.
module udp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000a3501fec0,
    parameter logic [31:0] LOCAL_IP   = 32'hc0a80002,
    parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
    input  logic        gmii_rx_clk,
    input  logic        reset,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  data_from_eth,
    output logic        valid_from_eth,
    output logic [9:0]  counter_from_eth,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] drop_cnt
);
    localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD_FCS, DROP, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  hdr_cnt;
    logic [2:0]  pre_cnt;
    logic [9:0]  pay_cnt;
    logic [2:0]  post_cnt;
    logic [15:0] udp_len;
    logic [31:0] crc;
    logic        fld_ok, mac_loc, mac_bc;
    logic        byte_ok;
    logic [7:0]  mac_exp;
    logic        in_frame, sfd_seen, len_ok, pay_end;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hedb88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign in_frame = state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD_FCS};
    assign sfd_seen = (state == PREAMBLE) && (state_nxt == ETH_HDR);
    assign len_ok   = (udp_len >= 16'd8) && (udp_len <= 16'd1032);
    assign pay_end  = ({6'd0, pay_cnt} == (udp_len - 16'd9));

    always_comb begin
        mac_exp = 8'h00;
        case (hdr_cnt)
            5'd0:    mac_exp = LOCAL_MAC[47:40];
            5'd1:    mac_exp = LOCAL_MAC[39:32];
            5'd2:    mac_exp = LOCAL_MAC[31:24];
            5'd3:    mac_exp = LOCAL_MAC[23:16];
            5'd4:    mac_exp = LOCAL_MAC[15:8];
            5'd5:    mac_exp = LOCAL_MAC[7:0];
            default: mac_exp = 8'h00;
        endcase
    end

    // Per-byte field check; fld_ok accumulates it across the current header.
    always_comb begin
        byte_ok = 1'b1;
        case (state)
            ETH_HDR: begin
                if (hdr_cnt == 5'd12) byte_ok = (gmii_rxd == 8'h08);
                if (hdr_cnt == 5'd13) byte_ok = (gmii_rxd == 8'h00);
            end
            IP_HDR: begin
                case (hdr_cnt)
                    5'd0:    byte_ok = (gmii_rxd == 8'h45);
                    5'd9:    byte_ok = (gmii_rxd == 8'h11);
                    5'd16:   byte_ok = (gmii_rxd == LOCAL_IP[31:24]);
                    5'd17:   byte_ok = (gmii_rxd == LOCAL_IP[23:16]);
                    5'd18:   byte_ok = (gmii_rxd == LOCAL_IP[15:8]);
                    5'd19:   byte_ok = (gmii_rxd == LOCAL_IP[7:0]);
                    default: byte_ok = 1'b1;
                endcase
            end
            UDP_HDR: begin
                if (hdr_cnt == 5'd2) byte_ok = (gmii_rxd == LOCAL_PORT[15:8]);
                if (hdr_cnt == 5'd3) byte_ok = (gmii_rxd == LOCAL_PORT[7:0]);
            end
            default: byte_ok = 1'b1;
        endcase
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (gmii_rx_dv) state_nxt = (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
            PREAMBLE:
                if (!gmii_rx_dv)                              state_nxt = DROP;
                else if (gmii_rxd == 8'hd5)                   state_nxt = ETH_HDR;
                else if (gmii_rxd != 8'h55 || pre_cnt == 3'd7) state_nxt = DROP;
            ETH_HDR:
                if (!gmii_rx_dv) state_nxt = DONE;
                else if (hdr_cnt == 5'd13)
                    state_nxt = (fld_ok && byte_ok && (mac_loc || mac_bc)) ? IP_HDR : DROP;
            IP_HDR:
                if (!gmii_rx_dv) state_nxt = DONE;
                else if (hdr_cnt == 5'd19)
                    state_nxt = (fld_ok && byte_ok) ? UDP_HDR : DROP;
            UDP_HDR:
                if (!gmii_rx_dv) state_nxt = DONE;
                else if (hdr_cnt == 5'd7) begin
                    if (!(fld_ok && len_ok))   state_nxt = DROP;
                    else if (udp_len == 16'd8) state_nxt = PAD_FCS;
                    else                       state_nxt = PAYLOAD;
                end
            PAYLOAD:
                if (!gmii_rx_dv)  state_nxt = DONE;
                else if (pay_end) state_nxt = PAD_FCS;
            PAD_FCS:
                if (!gmii_rx_dv) state_nxt = DONE;
            DROP:
                if (!gmii_rx_dv) state_nxt = IDLE;
            DONE:
                if (!gmii_rx_dv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            hdr_cnt          <= '0;
            pre_cnt          <= '0;
            pay_cnt          <= '0;
            post_cnt         <= '0;
            udp_len          <= '0;
            crc              <= 32'hffffffff;
            fld_ok           <= 1'b0;
            mac_loc          <= 1'b0;
            mac_bc           <= 1'b0;
            data_from_eth    <= '0;
            valid_from_eth   <= 1'b0;
            counter_from_eth <= '0;
            frame_done       <= 1'b0;
            frame_ok         <= 1'b0;
            drop_cnt         <= '0;
        end else begin
            valid_from_eth <= 1'b0;
            frame_done     <= 1'b0;
            frame_ok       <= 1'b0;

            if (state_nxt != state) begin
                hdr_cnt <= '0;
                fld_ok  <= 1'b1;
            end else if (gmii_rx_dv) begin
                hdr_cnt <= hdr_cnt + 5'd1;
                fld_ok  <= fld_ok & byte_ok;
            end

            if (state == IDLE)                       pre_cnt <= 3'd1;
            else if (state == PREAMBLE && gmii_rx_dv) pre_cnt <= pre_cnt + 3'd1;

            if (sfd_seen) begin
                mac_loc <= 1'b1;
                mac_bc  <= 1'b1;
            end else if (state == ETH_HDR && gmii_rx_dv && hdr_cnt < 5'd6) begin
                mac_loc <= mac_loc & (gmii_rxd == mac_exp);
                mac_bc  <= mac_bc & (gmii_rxd == 8'hff);
            end

            // FCS bytes go through the CRC too, so a clean frame leaves the fixed residue.
            if (sfd_seen)                    crc <= 32'hffffffff;
            else if (in_frame && gmii_rx_dv) crc <= crc_step(crc, gmii_rxd);

            if (state == UDP_HDR && gmii_rx_dv) begin
                if (hdr_cnt == 5'd4) udp_len[15:8] <= gmii_rxd;
                if (hdr_cnt == 5'd5) udp_len[7:0]  <= gmii_rxd;
            end

            if (state != PAYLOAD) begin
                pay_cnt <= '0;
            end else if (gmii_rx_dv) begin
                pay_cnt          <= pay_cnt + 10'd1;
                data_from_eth    <= gmii_rxd;
                valid_from_eth   <= 1'b1;
                counter_from_eth <= pay_cnt;
            end

            if (state != PAD_FCS)                       post_cnt <= '0;
            else if (gmii_rx_dv && post_cnt != 3'd4)    post_cnt <= post_cnt + 3'd1;

            if (state_nxt == DONE && state != DONE) begin
                frame_done <= 1'b1;
                frame_ok   <= (state == PAD_FCS) && (post_cnt == 3'd4) && (crc == CRC_RESIDUE);
            end

            if (state == DROP && !gmii_rx_dv && drop_cnt != 16'hffff)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_udp_rx_parser.sv
// Bench for udp_rx_parser: frames built from header fields, expectations from the filtering rules.
module tb_udp_rx_parser;
    localparam logic [47:0] LOCAL_MAC  = 48'h000a3501fec0;
    localparam logic [31:0] LOCAL_IP   = 32'hc0a80002;
    localparam logic [15:0] LOCAL_PORT = 16'd8080;
    localparam logic [47:0] BCAST      = 48'hffffffffffff;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_dv;
    logic [7:0]  rxd;
    logic [7:0]  data_from_eth;
    logic        valid_from_eth;
    logic [9:0]  counter_from_eth;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    udp_rx_parser #(.LOCAL_MAC(LOCAL_MAC), .LOCAL_IP(LOCAL_IP), .LOCAL_PORT(LOCAL_PORT)) dut (
        .gmii_rx_clk(clk), .reset(reset), .gmii_rx_dv(rx_dv), .gmii_rxd(rxd),
        .data_from_eth(data_from_eth), .valid_from_eth(valid_from_eth),
        .counter_from_eth(counter_from_eth), .frame_done(frame_done),
        .frame_ok(frame_ok), .drop_cnt(drop_cnt)
    );

    logic [7:0] frm[$];
    logic [7:0] pay[$];
    logic [7:0] obs_dat[$];
    logic [9:0] obs_cnt[$];
    logic       obs_ok[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         exp_drop = 0;

    initial forever begin
        @(negedge clk);
        if (valid_from_eth === 1'b1) begin
            obs_dat.push_back(data_from_eth);
            obs_cnt.push_back(counter_from_eth);
        end
        if (frame_done === 1'b1) obs_ok.push_back(frame_ok);
    end

    function automatic bit model_accept(input logic [47:0] mac, input logic [15:0] etype,
                                        input logic [7:0] vihl, input logic [7:0] proto,
                                        input logic [31:0] ip, input logic [15:0] port,
                                        input logic [15:0] ulen);
        return (mac == LOCAL_MAC || mac == BCAST) && etype == 16'h0800 && vihl == 8'h45 &&
               proto == 8'h11 && ip == LOCAL_IP && port == LOCAL_PORT && ulen >= 16'd8 && ulen <= 16'd1032;
    endfunction

    task automatic push_field(input logic [47:0] v, input int nbytes);
        for (int k = nbytes - 1; k >= 0; k--) frm.push_back(8'(v >> (8 * k)));
    endtask

    task automatic build_frame(input logic [47:0] mac, input logic [15:0] etype, input logic [7:0] vihl,
                               input logic [7:0] proto, input logic [31:0] ip, input logic [15:0] port,
                               input logic [15:0] ulen, input int npay, input bit seq_pay, input bit flip);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        pay.delete();
        push_field(mac, 6);
        push_field(48'h020000000001, 6);
        push_field(48'(etype), 2);
        push_field(48'(vihl), 1);
        push_field(48'h0, 1);
        push_field(48'(ulen + 16'd20), 2);
        push_field(48'($urandom), 2);
        push_field(48'h4000, 2);
        push_field(48'h40, 1);
        push_field(48'(proto), 1);
        push_field(48'h0, 2);
        push_field(48'hc0a80001, 4);
        push_field(48'(ip), 4);
        push_field(48'd1234, 2);
        push_field(48'(port), 2);
        push_field(48'(ulen), 2);
        push_field(48'h0, 2);
        for (int i = 0; i < npay; i++) begin
            b = seq_pay ? 8'(i) : 8'($urandom);
            pay.push_back(b);
            frm.push_back(b);
        end
        while (frm.size() < 60) frm.push_back(8'h00);
        c = 32'hffffffff;
        foreach (frm[i])
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ frm[i][j]) ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(8'(c >> (8 * k)));
        if (flip) frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h10;
    endtask

    task automatic clear_obs();
        obs_dat.delete();
        obs_cnt.delete();
        obs_ok.delete();
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1;
            rxd   = (i == 7) ? 8'hd5 : 8'h55;
        end
    endtask

    task automatic send_gap(input int gap);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b0;
            rxd   = 8'($urandom);
        end
    endtask

    task automatic send_frame(input int nbytes, input int gap);
        send_preamble();
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            rxd = frm[i];
        end
        send_gap(gap);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_dv = 1'b0; rxd = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++; if (valid_from_eth !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid_from_eth); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL reset_done got %0b want 0", frame_done); else n_pass++;
        n_total++; if (frame_ok !== 1'b0) $display("FAIL reset_ok got %0b want 0", frame_ok); else n_pass++;
        n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else n_pass++;
        n_total++; if (data_from_eth !== 8'h00) $display("FAIL reset_data got %h want 00", data_from_eth); else n_pass++;
        n_total++; if (counter_from_eth !== 10'd0) $display("FAIL reset_counter got %0d want 0", counter_from_eth); else n_pass++;
        exp_drop = 0;
    endtask

    task automatic test_good_frame(input bit flip);
        logic [7:0] got;
        logic [9:0] gcnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd18, 10, 1'b1, flip);
        clear_obs();
        send_frame(frm.size(), 6);
        n_total++; if (obs_dat.size() != 10) $display("FAIL good%0d_nvalid got %0d want 10", flip, obs_dat.size()); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            got  = (i < obs_dat.size()) ? obs_dat[i] : 8'hxx;
            gcnt = (i < obs_cnt.size()) ? obs_cnt[i] : 10'hxxx;
            n_total++; if (got !== 8'(i)) $display("FAIL good%0d_data[%0d] got %h want %h", flip, i, got, 8'(i)); else n_pass++;
            n_total++; if (gcnt !== 10'(i)) $display("FAIL good%0d_cnt[%0d] got %0d want %0d", flip, i, gcnt, i); else n_pass++;
        end
        n_total++; if (obs_ok.size() != 1) $display("FAIL good%0d_ndone got %0d want 1", flip, obs_ok.size()); else n_pass++;
        n_total++; if (obs_ok.size() > 0 && obs_ok[0] !== !flip) $display("FAIL good%0d_ok got %0b want %0b", flip, obs_ok[0], !flip); else n_pass++;
        n_total++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL good%0d_drop got %0d want %0d", flip, drop_cnt, exp_drop); else n_pass++;
    endtask

    task automatic test_filter_drop();
        logic [15:0] p, et;
        logic [31:0] ip;
        clear_obs();
        for (int k = 0; k < 3; k++) begin
            p  = (k == 0) ? 16'd8081 : LOCAL_PORT;
            ip = (k == 1) ? 32'hc0a80003 : LOCAL_IP;
            et = (k == 2) ? 16'h0806 : 16'h0800;
            build_frame(LOCAL_MAC, et, 8'h45, 8'h11, ip, p, 16'd18, 10, 1'b0, 1'b0);
            send_frame(frm.size(), 5);
            if (!model_accept(LOCAL_MAC, et, 8'h45, 8'h11, ip, p, 16'd18)) exp_drop++;
            n_total++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL filter_drop[%0d] got %0d want %0d", k, drop_cnt, exp_drop); else n_pass++;
        end
        n_total++; if (obs_dat.size() != 0) $display("FAIL filter_nvalid got %0d want 0", obs_dat.size()); else n_pass++;
        n_total++; if (obs_ok.size() != 0) $display("FAIL filter_ndone got %0d want 0", obs_ok.size()); else n_pass++;
    endtask

    task automatic test_max_len();
        int mism;
        build_frame(BCAST, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd1032, 1024, 1'b0, 1'b0);
        clear_obs();
        send_frame(frm.size(), 6);
        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (i >= obs_dat.size() || obs_dat[i] !== pay[i] || obs_cnt[i] !== 10'(i)) mism++;
        n_total++; if (obs_dat.size() != 1024) $display("FAIL max_nvalid got %0d want 1024", obs_dat.size()); else n_pass++;
        n_total++; if (mism != 0) $display("FAIL max_payload got %0d bad bytes want 0", mism); else n_pass++;
        n_total++; if (obs_cnt.size() == 0 || obs_cnt[obs_cnt.size() - 1] !== 10'd1023)
            $display("FAIL max_last_cnt got %0d want 1023", obs_cnt.size() ? obs_cnt[obs_cnt.size() - 1] : 10'd0); else n_pass++;
        n_total++; if (obs_ok.size() != 1 || obs_ok[0] !== 1'b1) $display("FAIL max_ok got %0d dones want one good", obs_ok.size()); else n_pass++;

        build_frame(BCAST, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd1033, 1025, 1'b0, 1'b0);
        clear_obs();
        send_frame(frm.size(), 6);
        exp_drop++;
        n_total++; if (obs_dat.size() != 0) $display("FAIL over_nvalid got %0d want 0", obs_dat.size()); else n_pass++;
        n_total++; if (obs_ok.size() != 0) $display("FAIL over_ndone got %0d want 0", obs_ok.size()); else n_pass++;
        n_total++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL over_drop got %0d want %0d", drop_cnt, exp_drop); else n_pass++;
    endtask

    task automatic test_truncated();
        logic [7:0] got;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd18, 10, 1'b1, 1'b0);
        clear_obs();
        send_frame(14 + 20 + 8 + 6, 6);
        n_total++; if (obs_dat.size() != 6) $display("FAIL trunc_nvalid got %0d want 6", obs_dat.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            got = (i < obs_dat.size()) ? obs_dat[i] : 8'hxx;
            n_total++; if (got !== 8'(i)) $display("FAIL trunc_data[%0d] got %h want %h", i, got, 8'(i)); else n_pass++;
        end
        n_total++; if (obs_ok.size() != 1) $display("FAIL trunc_ndone got %0d want 1", obs_ok.size()); else n_pass++;
        n_total++; if (obs_ok.size() > 0 && obs_ok[0] !== 1'b0) $display("FAIL trunc_ok got %0b want 0", obs_ok[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic v_after;
        int   mism;
        v_after = 1'bx;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd18, 10, 1'b1, 1'b0);
        clear_obs();
        send_preamble();
        for (int i = 0; i < frm.size(); i++) begin
            @(posedge clk); #1;
            if (i == 46) v_after = valid_from_eth;
            reset = (i == 45);
            rxd   = frm[i];
        end
        send_gap(6);
        exp_drop = 1;
        n_total++; if (v_after !== 1'b0) $display("FAIL rstmid_valid_after got %0b want 0", v_after); else n_pass++;
        n_total++; if (obs_dat.size() != 3) $display("FAIL rstmid_nvalid got %0d want 3", obs_dat.size()); else n_pass++;
        n_total++; if (obs_ok.size() != 0) $display("FAIL rstmid_ndone got %0d want 0", obs_ok.size()); else n_pass++;
        n_total++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL rstmid_drop got %0d want %0d", drop_cnt, exp_drop); else n_pass++;

        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 16'd28, 20, 1'b0, 1'b0);
        clear_obs();
        send_frame(frm.size(), 6);
        mism = 0;
        for (int i = 0; i < 20; i++)
            if (i >= obs_dat.size() || obs_dat[i] !== pay[i] || obs_cnt[i] !== 10'(i)) mism++;
        n_total++; if (obs_dat.size() != 20 || mism != 0) $display("FAIL rstmid_next_payload got %0d valids %0d bad want 20 valids 0 bad", obs_dat.size(), mism); else n_pass++;
        n_total++; if (obs_ok.size() != 1 || obs_ok[0] !== 1'b1) $display("FAIL rstmid_next_ok got %0d dones want one good", obs_ok.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [47:0] mac;
        logic [15:0] et, port, ulen;
        logic [7:0]  vihl, proto;
        logic [31:0] ip;
        int          npay, mism, exp_valid;
        bit          flip, acc;
        for (int f = 0; f < 25; f++) begin
            case ($urandom_range(0, 5))
                0:       mac = BCAST;
                1:       mac = LOCAL_MAC ^ (48'h1 << $urandom_range(0, 47));
                default: mac = LOCAL_MAC;
            endcase
            et    = ($urandom_range(0, 5) == 0) ? 16'h0806 : 16'h0800;
            vihl  = ($urandom_range(0, 7) == 0) ? 8'h46 : 8'h45;
            proto = ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h11;
            ip    = ($urandom_range(0, 5) == 0) ? (LOCAL_IP ^ (32'h1 << $urandom_range(0, 31))) : LOCAL_IP;
            port  = ($urandom_range(0, 5) == 0) ? (LOCAL_PORT ^ (16'h1 << $urandom_range(0, 15))) : LOCAL_PORT;
            if ($urandom_range(0, 5) == 0) begin
                ulen = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(1033, 1100));
                npay = 4;
            end else begin
                npay = $urandom_range(0, 40);
                ulen = 16'(npay + 8);
            end
            flip = ($urandom_range(0, 3) == 0);
            acc  = model_accept(mac, et, vihl, proto, ip, port, ulen);
            exp_valid = acc ? npay : 0;
            if (!acc) exp_drop++;
            build_frame(mac, et, vihl, proto, ip, port, ulen, npay, 1'b0, flip);
            clear_obs();
            send_frame(frm.size(), $urandom_range(4, 8));
            mism = 0;
            for (int i = 0; i < exp_valid; i++)
                if (i >= obs_dat.size() || obs_dat[i] !== pay[i] || obs_cnt[i] !== 10'(i)) mism++;
            n_total++; if (obs_dat.size() != exp_valid) $display("FAIL b2b[%0d]_nvalid got %0d want %0d", f, obs_dat.size(), exp_valid); else n_pass++;
            n_total++; if (mism != 0) $display("FAIL b2b[%0d]_payload got %0d bad bytes want 0", f, mism); else n_pass++;
            n_total++; if (obs_ok.size() != int'(acc)) $display("FAIL b2b[%0d]_ndone got %0d want %0d", f, obs_ok.size(), acc); else n_pass++;
            n_total++; if (acc && obs_ok.size() > 0 && obs_ok[0] !== !flip) $display("FAIL b2b[%0d]_ok got %0b want %0b", f, obs_ok[0], !flip); else n_pass++;
            n_total++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL b2b[%0d]_drop got %0d want %0d", f, drop_cnt, exp_drop); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_dv = 1'b0;
        rxd   = 8'h00;
        test_reset();
        test_good_frame(1'b0);
        test_good_frame(1'b1);
        test_filter_drop();
        test_max_len();
        test_truncated();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
